// File: rtl/fifo_n.sv
// Parametrised synchronous FIFO with level count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_N_SVA_EN to compile the embedded concurrent assertions.
module fifo_n #(
  parameter int DW     = 8,
  parameter int AW     = 2,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_AF  = (AW+1)'(AF_LVL);
  localparam logic [AW:0]   LVL_AE  = (AW+1)'(AE_LVL);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr_ok;
  logic          rd_ok;

  // Flags are pure decodes of level so they can never disagree with it.
  assign full   = (level == LVL_MAX);
  assign empty  = (level == '0);
  assign afull  = (level >= LVL_AF);
  assign aempty = (level <= LVL_AE);
  assign dout   = mem[rp];

  // A simultaneous read frees the slot, so a full FIFO still accepts the write.
  assign wr_ok = we & (~full | re) & ~clr;
  assign rd_ok = re & ~empty & ~clr;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + PTR_ONE;
      end
      if (rd_ok) begin
        rp <= rp + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (we && full && !re) begin
        ovf <= 1'b1;
      end
      if (re && empty) begin
        udf <= 1'b1;
      end
    end
  end

`ifdef FIFO_N_SVA_EN
  a_full_empty: assert property (@(posedge clk) disable iff (!rst) !(full && empty));

  a_level_max: assert property (@(posedge clk) disable iff (!rst) level <= LVL_MAX);

  // Equal pointers mean either empty or full; full tells the two apart.
  a_ptr_level: assert property (@(posedge clk) disable iff (!rst)
    (AW'(wp - rp) == level[AW-1:0]) && ((wp != rp) || empty || full));

  a_ovf_rise: assert property (@(posedge clk) disable iff (!rst) !$rose(ovf))
    else $error("%m: write dropped while full (overflow)");

  a_udf_rise: assert property (@(posedge clk) disable iff (!rst) !$rose(udf))
    else $error("%m: read attempted while empty (underflow)");
`else
`endif

endmodule

// File: doc/fifo_n.md
# fifo_n

Parametrised synchronous FIFO, successor to the fixed 4-entry `fifo4` used by the SPI core's write and read buffers. It generalises data width and depth and adds a level count, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It also defines legal simultaneous read/write. Intended as a drop-in for `spi` buffers and other byte/word streaming paths in the design.

## Interface
Parameters:
- `DW`, 8, data width in bits.
- `AW`, 2, address width; depth = 2**AW (legal AW 1..6).
- `AF_LVL`, 3, afull asserts when level >= AF_LVL (1..2**AW).
- `AE_LVL`, 1, aempty asserts when level <= AE_LVL (0..2**AW-1).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear.
- `we`   in  1  write request.
- `din`  in  DW  write data.
- `re`   in  1  read request (pops head).
- `dout` out DW  head entry (show-ahead, combinational from memory).
- `full` out 1  level == 2**AW.
- `empty` out 1  level == 0.
- `afull` out 1  level >= AF_LVL.
- `aempty` out 1  level <= AE_LVL.
- `level` out AW+1  current occupancy, 0..2**AW.
- `ovf`  out 1  sticky: write attempted while full and not accepted.
- `udf`  out 1  sticky: read attempted while empty.

## Operation
- Storage: 2**AW x DW array, not reset. Write pointer `wp`, read pointer `rp`, each AW bits, wrap modulo 2**AW.
- Flags `full`, `empty`, `afull`, `aempty` are decoded from the registered `level`. They are never separately registered, so they cannot disagree with `level`.
- Per-cycle priority, highest first:
  - `clr`=1: `wp`=`rp`=0, `level`=0, `ovf`=`udf`=0. `we`/`re` in that cycle are ignored and flag nothing.
  - Otherwise compute `wr_ok` = `we` & (!`full` | `re`) and `rd_ok` = `re` & !`empty`.
- `wr_ok`: `mem[wp]`<=`din`, `wp`+=1.
- `rd_ok`: `rp`+=1.
- `level` += `wr_ok` - `rd_ok`.
- `we` & `full` & !`re`: write dropped, `ovf`<=1.
- `re` & `empty`: read ignored, `udf`<=1. If `we` is also set, the write is still accepted. There is no read-through bypass.
- `re` & `we` & `full`: both are performed, `level` is unchanged, and no overflow is flagged.
- `re` & `we` with 0 < `level` < max: both are performed and `level` is unchanged.
- `dout` = `mem[rp]`. It is valid only while !`empty` and is undefined otherwise.
- `ovf`/`udf` are cleared only by `clr` or reset.

## Timing
- Reset (`rst` low, asynchronous): `wp`=`rp`=0, `level`=0, `empty`=1, `full`=0, `afull`=0 (AF_LVL>=1), `aempty`=1, `ovf`=`udf`=0. `dout` is undefined.
- Write latency: data written at edge N is visible on `dout` after edge N if the FIFO was empty. `empty` deasserts after edge N.
- Read: `dout` shows the next entry immediately after the popping edge.
- Flags, `level`, `ovf`, `udf` all update on the same edge as the pointers.
- Reset deassertion mid-stream: the FIFO restarts empty, and any write in the first cycle after release is accepted normally.

## Configuration
- `FIFO_N_SVA_EN`: when defined, embedded concurrent assertions are compiled, disabled while `rst` is low:
  - `full` and `empty` are never both 1.
  - `level` <= 2**AW.
  - `level` equals `wp`-`rp` modulo 2**AW, with `full` distinguishing the two cases where that difference is 0.
  - A rising edge of `ovf` or `udf` raises an `$error` naming the instance.
- When `FIFO_N_SVA_EN` is undefined, no assertions are compiled. RTL behaviour is identical in both cases.

## Test plan
All scenarios use DW=8, AW=2, AF_LVL=3, AE_LVL=1.
- Reset, then write 0x11,0x22,0x33,0x44: `level` 1,2,3,4; `afull` from level 3; `full`=1 after the 4th write. Then read four times: `dout` 0x11,0x22,0x33,0x44 and `empty`=1.
- Full FIFO with `we`=1, `din`=0x55, `re`=0 -> `ovf`=1, `level` stays 4, and the contents are unchanged on readback.
- Full FIFO with `re`=`we`=1, `din`=0x66 -> `level` 4, `ovf`=0, 0x66 read last after the wrap.
- Empty FIFO with `re`=`we`=1, `din`=0x77 -> `udf`=1, `level` 1, `dout`=0x77.
- 10 write/read pairs to exercise pointer wrap -> data is in order and `level` ends at 0. Then assert `clr` with `we`=1 -> `level` 0, `ovf`/`udf` 0, the write is ignored.
- Assert `rst` low with `level`=3 -> all outputs take reset values asynchronously, before the next clock edge.
